// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the Selen pipeline sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DWAIT,
    ST_FLUSH
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/cpu_pipe_ctrl_s_if.sv
// Control bus between the pipeline datapath (master) and the sequencer (slave).
interface cpu_pipe_ctrl_s_if #(
  parameter int REG_AW = 5,
  parameter int PCNT_W = 16
);
  logic [3*REG_AW-1:0] dec_hazard_bus;
  logic [REG_AW-1:0]   exe_rd;
  logic                exe_we;
  logic                exe_is_ld;
  logic [REG_AW-1:0]   mem_rd;
  logic                mem_we;
  logic                mem_req;
  logic                dl1_ack;
  logic                il1_ack;
  logic                exe_brnch_taken;
  logic                if_enb;
  logic                dec_enb;
  logic                dec_kill;
  logic                dec_nop_gen;
  logic                exe_enb;
  logic                mem_enb;
  logic                pc_sel;
  logic [1:0]          fwd_src1_sel;
  logic [1:0]          fwd_src2_sel;
  logic [PCNT_W-1:0]   stall_cnt;

  modport master (
    output dec_hazard_bus, exe_rd, exe_we, exe_is_ld, mem_rd, mem_we,
           mem_req, dl1_ack, il1_ack, exe_brnch_taken,
    input  if_enb, dec_enb, dec_kill, dec_nop_gen, exe_enb, mem_enb,
           pc_sel, fwd_src1_sel, fwd_src2_sel, stall_cnt
  );

  modport slave (
    input  dec_hazard_bus, exe_rd, exe_we, exe_is_ld, mem_rd, mem_we,
           mem_req, dl1_ack, il1_ack, exe_brnch_taken,
    output if_enb, dec_enb, dec_kill, dec_nop_gen, exe_enb, mem_enb,
           pc_sel, fwd_src1_sel, fwd_src2_sel, stall_cnt
  );
endinterface

// File: rtl/cpu_fwd_unit_s.sv
// Operand forwarding select for both decode sources; EXE result wins over MEM/WB.
module cpu_fwd_unit_s
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] exe_rd,
  input  logic              exe_we,
  input  logic              exe_is_ld,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  output logic [1:0]        src1_sel,
  output logic [1:0]        src2_sel
);

  // A load in EXE has no result yet, so it never forwards from EXE.
  assign src1_sel = (rs1 == '0)                                 ? FWD_RF  :
                    (exe_we && !exe_is_ld && (exe_rd == rs1))    ? FWD_EXE :
                    (mem_we && (mem_rd == rs1))                  ? FWD_MEM :
                                                                   FWD_RF;

  assign src2_sel = (rs2 == '0)                                 ? FWD_RF  :
                    (exe_we && !exe_is_ld && (exe_rd == rs2))    ? FWD_EXE :
                    (mem_we && (mem_rd == rs2))                  ? FWD_MEM :
                                                                   FWD_RF;

endmodule

// File: rtl/cpu_pipe_ctrl_s.sv
// Selen pipeline sequencer: stage enables/kills, redirect, flush and DL1-wait handling.
module cpu_pipe_ctrl_s
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int PCNT_W      = 16
) (
  input logic               clk,
  input logic               rst_n,
  cpu_pipe_ctrl_s_if.slave  ctl
);

  localparam int CNT_W = (FLUSH_DEPTH < 2) ? 1 : $clog2(FLUSH_DEPTH + 1);

  ctrl_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PCNT_W-1:0] stall_q;

  logic [REG_AW-1:0] rs1, rs2;
  logic              freeze, load_use;
  logic              if_enb, dec_enb, dec_kill, dec_nop_gen, exe_enb, mem_enb, pc_sel;
  logic [1:0]        f1_sel, f2_sel;

  assign rs1 = ctl.dec_hazard_bus[3*REG_AW-1 -: REG_AW];
  assign rs2 = ctl.dec_hazard_bus[2*REG_AW-1 -: REG_AW];

  cpu_fwd_unit_s #(.REG_AW(REG_AW)) u_fwd (
    .rs1       (rs1),
    .rs2       (rs2),
    .exe_rd    (ctl.exe_rd),
    .exe_we    (ctl.exe_we),
    .exe_is_ld (ctl.exe_is_ld),
    .mem_rd    (ctl.mem_rd),
    .mem_we    (ctl.mem_we),
    .src1_sel  (f1_sel),
    .src2_sel  (f2_sel)
  );

  always_comb begin
    load_use = ctl.exe_is_ld && ctl.exe_we && (ctl.exe_rd != '0) &&
               ((ctl.exe_rd == rs1) || (ctl.exe_rd == rs2));
    // Once in DWAIT only the ack releases the freeze, whatever mem_req does.
    freeze   = (state == ST_DWAIT) ? !ctl.dl1_ack : (ctl.mem_req && !ctl.dl1_ack);
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    if_enb      = 1'b0;
    dec_enb     = 1'b0;
    dec_kill    = 1'b0;
    dec_nop_gen = 1'b0;
    exe_enb     = 1'b0;
    mem_enb     = 1'b0;
    pc_sel      = 1'b0;
    case (state)
      ST_INIT: begin
        dec_kill    = 1'b1;
        dec_nop_gen = 1'b1;
        state_nxt   = ST_RUN;
      end
      ST_RUN, ST_DWAIT: begin
        if (freeze) begin
          state_nxt = ST_DWAIT;
        end else if (ctl.exe_brnch_taken) begin
          pc_sel      = 1'b1;
          if_enb      = 1'b1;
          dec_enb     = 1'b1;
          dec_kill    = 1'b1;
          dec_nop_gen = 1'b1;
          exe_enb     = 1'b1;
          mem_enb     = 1'b1;
          if (FLUSH_DEPTH == 1) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = CNT_W'(FLUSH_DEPTH - 1);
          end
        end else if (load_use) begin
          dec_kill  = 1'b1;
          exe_enb   = 1'b1;
          mem_enb   = 1'b1;
          state_nxt = ST_RUN;
        end else if (!ctl.il1_ack) begin
          dec_nop_gen = 1'b1;
          dec_enb     = 1'b1;
          exe_enb     = 1'b1;
          mem_enb     = 1'b1;
          state_nxt   = ST_RUN;
        end else begin
          if_enb    = 1'b1;
          dec_enb   = 1'b1;
          exe_enb   = 1'b1;
          mem_enb   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        dec_nop_gen = 1'b1;
        if (!(ctl.mem_req && !ctl.dl1_ack)) begin
          if_enb  = ctl.il1_ack;
          dec_enb = 1'b1;
          exe_enb = 1'b1;
          mem_enb = 1'b1;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      cnt     <= '0;
      stall_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // The reset-recovery cycle is not a pipeline stall.
      if ((state != ST_INIT) && !dec_enb && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign ctl.if_enb       = if_enb;
  assign ctl.dec_enb      = dec_enb;
  assign ctl.dec_kill     = dec_kill;
  assign ctl.dec_nop_gen  = dec_nop_gen;
  assign ctl.exe_enb      = exe_enb;
  assign ctl.mem_enb      = mem_enb;
  assign ctl.pc_sel       = pc_sel;
  assign ctl.fwd_src1_sel = (state == ST_INIT) ? FWD_RF : f1_sel;
  assign ctl.fwd_src2_sel = (state == ST_INIT) ? FWD_RF : f2_sel;
  assign ctl.stall_cnt    = stall_q;

endmodule

// File: tb/tb_cpu_pipe_ctrl_s.sv
// Bench for cpu_pipe_ctrl_s: directed scenarios plus random traffic against a behavioural model.
module tb_cpu_pipe_ctrl_s;

  localparam int AW = 5;
  localparam int M_INIT = 0, M_RUN = 1, M_WAIT = 2, M_FLUSH = 3;

  typedef struct {
    bit rst_n;
    int rs1, rs2, rd, exe_rd, mem_rd;
    bit exe_we, exe_ld, mem_we, mem_req, dl1_ack, il1_ack, br;
  } stim_t;

  typedef struct {
    int if_e, dec_e, kill, nop, exe_e, mem_e, pc, f1, f2, stall;
  } out_t;

  typedef struct {
    int mode;
    int cnt;
    int stall;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_pipe_ctrl_s_if #(.REG_AW(AW), .PCNT_W(16)) bus0 ();
  cpu_pipe_ctrl_s_if #(.REG_AW(AW), .PCNT_W(4))  bus1 ();

  cpu_pipe_ctrl_s #(.REG_AW(AW), .FLUSH_DEPTH(2), .PCNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .ctl(bus0));
  cpu_pipe_ctrl_s #(.REG_AW(AW), .FLUSH_DEPTH(3), .PCNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctl(bus1));

  int   n_tests = 0;
  int   n_fail  = 0;
  stim_t cur;
  mdl_t  m0, m1, n0, n1;
  out_t  e0, e1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fwd_of(input int rs, input stim_t s);
    if (rs == 0) return 0;
    if (s.exe_we && !s.exe_ld && s.exe_rd == rs) return 1;
    if (s.mem_we && s.mem_rd == rs) return 2;
    return 0;
  endfunction

  // Outputs for this cycle and the model state after the next clock edge.
  function automatic void predict(input mdl_t m, input stim_t s, input int depth,
                                  input int cmax, output out_t o, output mdl_t nx);
    bit stuck;
    o = '{default: 0};
    nx = m;
    o.stall = m.stall;
    if (m.mode == M_INIT) begin
      o.kill = 1; o.nop = 1;
      nx.mode = M_RUN;
      return;
    end
    o.f1 = fwd_of(s.rs1, s);
    o.f2 = fwd_of(s.rs2, s);
    stuck = (m.mode == M_WAIT) ? !s.dl1_ack : (s.mem_req && !s.dl1_ack);
    if (stuck) begin
      o.nop = (m.mode == M_FLUSH);
      if (m.mode != M_FLUSH) nx.mode = M_WAIT;
    end else if (m.mode == M_FLUSH) begin
      o.nop = 1; o.if_e = s.il1_ack; o.dec_e = 1; o.exe_e = 1; o.mem_e = 1;
      nx.cnt = m.cnt - 1;
      if (nx.cnt == 0) nx.mode = M_RUN;
    end else if (s.br) begin
      o.pc = 1; o.if_e = 1; o.dec_e = 1; o.kill = 1; o.nop = 1; o.exe_e = 1; o.mem_e = 1;
      nx.mode = (depth == 1) ? M_RUN : M_FLUSH;
      nx.cnt  = depth - 1;
    end else if (s.exe_ld && s.exe_we && s.exe_rd != 0 &&
                 (s.exe_rd == s.rs1 || s.exe_rd == s.rs2)) begin
      o.kill = 1; o.exe_e = 1; o.mem_e = 1;
      nx.mode = M_RUN;
    end else if (!s.il1_ack) begin
      o.nop = 1; o.dec_e = 1; o.exe_e = 1; o.mem_e = 1;
      nx.mode = M_RUN;
    end else begin
      o.if_e = 1; o.dec_e = 1; o.exe_e = 1; o.mem_e = 1;
      nx.mode = M_RUN;
    end
    nx.stall = (o.dec_e == 0 && m.stall < cmax) ? m.stall + 1 : m.stall;
  endfunction

  function automatic out_t obs0();
    out_t o;
    o.if_e = bus0.if_enb;  o.dec_e = bus0.dec_enb; o.kill = bus0.dec_kill;
    o.nop = bus0.dec_nop_gen; o.exe_e = bus0.exe_enb; o.mem_e = bus0.mem_enb;
    o.pc = bus0.pc_sel; o.f1 = bus0.fwd_src1_sel; o.f2 = bus0.fwd_src2_sel;
    o.stall = bus0.stall_cnt;
    return o;
  endfunction

  function automatic out_t obs1();
    out_t o;
    o.if_e = bus1.if_enb;  o.dec_e = bus1.dec_enb; o.kill = bus1.dec_kill;
    o.nop = bus1.dec_nop_gen; o.exe_e = bus1.exe_enb; o.mem_e = bus1.mem_enb;
    o.pc = bus1.pc_sel; o.f1 = bus1.fwd_src1_sel; o.f2 = bus1.fwd_src2_sel;
    o.stall = bus1.stall_cnt;
    return o;
  endfunction

  task automatic cmp(input string p, input out_t g, input out_t e);
    chk({p, ".if_enb"},  g.if_e,  e.if_e);
    chk({p, ".dec_enb"}, g.dec_e, e.dec_e);
    chk({p, ".dec_kill"}, g.kill, e.kill);
    chk({p, ".dec_nop"}, g.nop,   e.nop);
    chk({p, ".exe_enb"}, g.exe_e, e.exe_e);
    chk({p, ".mem_enb"}, g.mem_e, e.mem_e);
    chk({p, ".pc_sel"},  g.pc,    e.pc);
    chk({p, ".fwd1"},    g.f1,    e.f1);
    chk({p, ".fwd2"},    g.f2,    e.f2);
    chk({p, ".stall"},   g.stall, e.stall);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rst_n = 1; s.dl1_ack = 1; s.il1_ack = 1;
    return s;
  endfunction

  task automatic apply_bus(input stim_t s);
    bus0.dec_hazard_bus  = {AW'(s.rs1), AW'(s.rs2), AW'(s.rd)};
    bus0.exe_rd = AW'(s.exe_rd); bus0.exe_we = s.exe_we; bus0.exe_is_ld = s.exe_ld;
    bus0.mem_rd = AW'(s.mem_rd); bus0.mem_we = s.mem_we; bus0.mem_req = s.mem_req;
    bus0.dl1_ack = s.dl1_ack; bus0.il1_ack = s.il1_ack; bus0.exe_brnch_taken = s.br;
    bus1.dec_hazard_bus  = {AW'(s.rs1), AW'(s.rs2), AW'(s.rd)};
    bus1.exe_rd = AW'(s.exe_rd); bus1.exe_we = s.exe_we; bus1.exe_is_ld = s.exe_ld;
    bus1.mem_rd = AW'(s.mem_rd); bus1.mem_we = s.mem_we; bus1.mem_req = s.mem_req;
    bus1.dl1_ack = s.dl1_ack; bus1.il1_ack = s.il1_ack; bus1.exe_brnch_taken = s.br;
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    cur = s;
    apply_bus(s);
    rst_n = s.rst_n;
    if (!s.rst_n) begin
      m0 = '{M_INIT, 0, 0};
      m1 = '{M_INIT, 0, 0};
    end
    #1;
    predict(m0, s, 2, 65535, e0, n0);
    predict(m1, s, 3, 15, e1, n1);
    cmp("d0", obs0(), e0);
    cmp("d1", obs1(), e1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur.rst_n) begin
      m0 = n0;
      m1 = n1;
    end
  endtask

  task automatic step(input stim_t s);
    drive(s);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    stim_t s;
    int    s0;
    m0 = '{M_INIT, 0, 0};
    m1 = '{M_INIT, 0, 0};
    rst_n = 1'b0;
    apply_bus(idle());

    // T1: reset held three cycles, then one INIT cycle, then full run
    s = idle(); s.rst_n = 0;
    repeat (3) step(s);
    drive(idle());
    chk("t1_init_kill", bus0.dec_kill, 1);
    chk("t1_init_enb", bus0.dec_enb, 0);
    tick();
    drive(idle());
    chk("t1_run_enb", bus0.dec_enb, 1);
    chk("t1_stall0", bus0.stall_cnt, 0);
    tick();

    // T2: load-use bubble, then MEM forwarding
    s = idle(); s.exe_rd = 5; s.exe_we = 1; s.exe_ld = 1; s.rs1 = 5;
    drive(s);
    chk("t2_bubble_enb", bus0.dec_enb, 0);
    chk("t2_bubble_kill", bus0.dec_kill, 1);
    tick();
    s = idle(); s.mem_rd = 5; s.mem_we = 1; s.rs1 = 5;
    drive(s);
    chk("t2_fwd_mem", bus0.fwd_src1_sel, 2);
    tick();

    // T3: EXE beats MEM; r0 never forwards
    s = idle(); s.exe_rd = 3; s.exe_we = 1; s.mem_rd = 3; s.mem_we = 1; s.rs2 = 3;
    drive(s);
    chk("t3_fwd_exe", bus0.fwd_src2_sel, 1);
    tick();
    s = idle(); s.exe_we = 1; s.mem_we = 1;
    drive(s);
    chk("t3_fwd_r0", bus0.fwd_src2_sel, 0);
    tick();

    // T4: taken branch with two-cycle flush
    s = idle(); s.br = 1;
    drive(s);
    chk("t4_pc_sel", bus0.pc_sel, 1);
    chk("t4_nop0", bus0.dec_nop_gen, 1);
    tick();
    drive(idle());
    chk("t4_pc_once", bus0.pc_sel, 0);
    chk("t4_nop1", bus0.dec_nop_gen, 1);
    tick();
    drive(idle());
    chk("t4_run_nop", bus0.dec_nop_gen, 0);
    tick();
    repeat (3) step(idle());

    // T5: DL1 miss with a held branch redirects on the ack cycle
    s = idle(); s.mem_req = 1; s.dl1_ack = 0; s.br = 1;
    drive(s);
    s0 = bus0.stall_cnt;
    tick();
    repeat (3) step(s);
    s.dl1_ack = 1;
    drive(s);
    chk("t5_pc_on_ack", bus0.pc_sel, 1);
    chk("t5_stall_plus4", bus0.stall_cnt, s0 + 4);
    tick();
    repeat (4) step(idle());

    // Reset in the middle of a DL1 wait discards the pending redirect
    s = idle(); s.mem_req = 1; s.dl1_ack = 0; s.br = 1;
    repeat (2) step(s);
    s.rst_n = 0;
    step(s);
    s = idle(); s.br = 0;
    drive(s);
    chk("rst_mid_pc", bus0.pc_sel, 0);
    chk("rst_mid_stall", bus0.stall_cnt, 0);
    tick();
    repeat (2) step(idle());

    // T6: saturating stall counter on the narrow instance
    s = idle(); s.mem_req = 1; s.dl1_ack = 0; s.il1_ack = 0;
    repeat (20) step(s);
    drive(idle());
    chk("t6_sat", bus1.stall_cnt, 15);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      s.rst_n   = ($urandom_range(99) != 0);
      s.rs1     = $urandom_range(7);
      s.rs2     = $urandom_range(7);
      s.rd      = $urandom_range(7);
      s.exe_rd  = $urandom_range(7);
      s.mem_rd  = $urandom_range(7);
      s.exe_we  = ($urandom_range(9) < 7);
      s.exe_ld  = ($urandom_range(9) < 3);
      s.mem_we  = ($urandom_range(9) < 7);
      s.mem_req = ($urandom_range(9) < 3);
      s.dl1_ack = ($urandom_range(9) < 5);
      s.il1_ack = ($urandom_range(9) < 8);
      s.br      = ($urandom_range(99) < 15);
      step(s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
